multdiv_unit: RTL

//   Iterative signed 32-bit multiply/divide unit. It sits beside the ALU in the

---
 rtl/multdiv_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit: radix-2 Booth multiply, restoring divide on magnitudes.
// Fixed latency of WIDTH iterations after the accept edge; one-cycle result-ready pulse.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_next;

    logic             op_mul, neg, div_zero, div_ovf;
    logic [WIDTH-1:0] operand;
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             acc_q;
    logic [CW-1:0]    count;

    logic start, accept, last;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign start          = ctrl_MULT | ctrl_DIV;
    assign accept         = start && (state == IDLE || state == DONE);
    assign last           = (state == RUN) && (count == CW'(WIDTH - 1));
    assign busy           = (state != IDLE);
    assign data_resultRDY = (state == DONE);

    // Unsigned magnitudes: the most negative value maps to 2^(WIDTH-1) without wrap.
    assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Booth step; acc_hi carries one guard bit so adding the most negative multiplicand cannot overflow.
    logic [WIDTH:0]     addend, mul_sum, mul_hi_n;
    logic [WIDTH-1:0]   mul_lo_n;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     prod_top;
    logic               mul_exc;

    always_comb begin
        addend = '0;
        case ({acc_lo[0], acc_q})
            2'b01:   addend = {operand[WIDTH-1], operand};
            2'b10:   addend = -{operand[WIDTH-1], operand};
            default: addend = '0;
        endcase
        mul_sum  = acc_hi + addend;
        mul_hi_n = {mul_sum[WIDTH], mul_sum[WIDTH:1]};
        mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
        product  = {mul_hi_n[WIDTH-1:0], mul_lo_n};
        prod_top = product[2*WIDTH-1:WIDTH-1];
        mul_exc  = !((&prod_top) || !(|prod_top));
    end

    logic [WIDTH:0]   shifted, div_hi_n;
    logic [WIDTH+1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] div_lo_n, div_result;

    always_comb begin
        shifted    = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        diff       = {1'b0, shifted} - {2'b00, operand};
        ge         = !diff[WIDTH+1];
        div_hi_n   = ge ? diff[WIDTH:0] : shifted;
        div_lo_n   = {acc_lo[WIDTH-2:0], ge};
        div_result = div_zero ? '0 : (neg ? -div_lo_n : div_lo_n);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_mul         <= 1'b0;
            neg            <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            operand        <= '0;
            acc_hi         <= '0;
            acc_lo         <= '0;
            acc_q          <= 1'b0;
            count          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (accept) begin
            op_mul   <= ctrl_MULT;
            operand  <= ctrl_MULT ? data_operandA : abs_b;
            acc_hi   <= '0;
            acc_lo   <= ctrl_MULT ? data_operandB : abs_a;
            acc_q    <= 1'b0;
            count    <= '0;
            neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
            div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
        end else if (state == RUN) begin
            count <= count + 1'b1;
            if (op_mul) begin
                acc_hi <= mul_hi_n;
                acc_lo <= mul_lo_n;
                acc_q  <= acc_lo[0];
            end else begin
                acc_hi <= div_hi_n;
                acc_lo <= div_lo_n;
            end
            if (last) begin
                data_result    <= op_mul ? product[WIDTH-1:0] : div_result;
                data_exception <= op_mul ? mul_exc : (div_zero | div_ovf);
            end
        end
    end
endmodule
